// File: rtl/psr_unit.sv
// psr_unit: 65C02 processor status register (N,V,D,I,Z,C) with the ALU
// flag-update request/acknowledge handshake.
//
// Ports:
//   fclk, resb           clock; synchronous active-high reset
//   psr_update_request   ALU request (level, held until acknowledged)
//   ack_update_request   one-cycle acknowledge back to the ALU
//   n/v/z/c_result       ALU flag results written on an accepted request
//   flag_op_valid/op     CLC SEC CLI SEI CLD SED CLV (7 = no-op)
//   plp_load, db_in      PLP/RTI load of the whole register
//   irq_entry            interrupt/BRK entry: set I, clear D
//   push_b               B bit for the pushed status byte
//   psr_push_out         {N,V,1,push_b,D,I,Z,C}
//   psr_to_id            {N,V,1,1,D,I,Z,C}
//   c_carry, d_decimal   current C and D
//   update_pending       handshake FSM not idle
//   protocol_error       sticky; request held too long after ack
module psr_unit #(
  parameter int          DROP_TIMEOUT = 4,
  parameter logic [7:0]  RESET_PSR    = 8'h34
) (
  input  logic       fclk,
  input  logic       resb,
  input  logic       psr_update_request,
  output logic       ack_update_request,
  input  logic       n_result,
  input  logic       v_result,
  input  logic       z_result,
  input  logic       c_result,
  input  logic       flag_op_valid,
  input  logic [2:0] flag_op,
  input  logic       plp_load,
  input  logic [7:0] db_in,
  input  logic       irq_entry,
  input  logic       push_b,
  output logic [7:0] psr_push_out,
  output logic [7:0] psr_to_id,
  output logic       c_carry,
  output logic       d_decimal,
  output logic       update_pending,
  output logic       protocol_error
);

  localparam int CW = $clog2(DROP_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(DROP_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          perr_q, perr_d;
  logic          accept;

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;

  assign cnt_inc = cnt_q + 1'b1;

  // Handshake FSM
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // a PLP on the same edge owns the register; defer the request
        if (psr_update_request && !plp_load) begin
          accept  = 1'b1;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = psr_update_request ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!psr_update_request) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == TMO) begin
          perr_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Flag next-state: lowest priority first, later writes win
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (accept) begin
      n_d = n_result;
      v_d = v_result;
      z_d = z_result;
      c_d = c_result;
    end
    if (flag_op_valid) begin
      case (flag_op)
        3'd0:    c_d = 1'b0;
        3'd1:    c_d = 1'b1;
        3'd2:    i_d = 1'b0;
        3'd3:    i_d = 1'b1;
        3'd4:    d_d = 1'b0;
        3'd5:    d_d = 1'b1;
        3'd6:    v_d = 1'b0;
        default: ;
      endcase
    end
    if (irq_entry) begin
      i_d = 1'b1;
      d_d = 1'b0;
    end
    if (plp_load) begin
      n_d = db_in[7];
      v_d = db_in[6];
      d_d = db_in[3];
      i_d = db_in[2];
      z_d = db_in[1];
      c_d = db_in[0];
    end
  end

  always_ff @(posedge fclk) begin
    if (resb) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
      n_q     <= RESET_PSR[7];
      v_q     <= RESET_PSR[6];
      d_q     <= RESET_PSR[3];
      i_q     <= RESET_PSR[2];
      z_q     <= RESET_PSR[1];
      c_q     <= RESET_PSR[0];
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
      n_q     <= n_d;
      v_q     <= v_d;
      d_q     <= d_d;
      i_q     <= i_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign ack_update_request = ack_q;
  assign update_pending     = (state_q != S_IDLE);
  assign protocol_error     = perr_q;
  assign c_carry            = c_q;
  assign d_decimal          = d_q;
  assign psr_to_id    = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
  assign psr_push_out = {n_q, v_q, 1'b1, push_b, d_q, i_q, z_q, c_q};

endmodule

// File: tb/tb_psr_unit.sv
// tb_psr_unit: directed literal checks plus randomized stimulus against
// a behavioural model of the status register and handshake.
module tb_psr_unit;

  localparam int DROP = 4;

  logic       fclk = 1'b0;
  logic       resb;
  logic       req;
  logic       ack;
  logic       n_r, v_r, z_r, c_r;
  logic       fov;
  logic [2:0] fop;
  logic       plp;
  logic [7:0] db;
  logic       irq;
  logic       pb;
  logic [7:0] push_out;
  logic [7:0] to_id;
  logic       cc, dd, pend, perr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 fclk = ~fclk;

  psr_unit #(.DROP_TIMEOUT(DROP), .RESET_PSR(8'h34)) dut (
    .fclk               (fclk),
    .resb               (resb),
    .psr_update_request (req),
    .ack_update_request (ack),
    .n_result           (n_r),
    .v_result           (v_r),
    .z_result           (z_r),
    .c_result           (c_r),
    .flag_op_valid      (fov),
    .flag_op            (fop),
    .plp_load           (plp),
    .db_in              (db),
    .irq_entry          (irq),
    .push_b             (pb),
    .psr_push_out       (push_out),
    .psr_to_id          (to_id),
    .c_carry            (cc),
    .d_decimal          (dd),
    .update_pending     (pend),
    .protocol_error     (perr)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_psr holds the status byte as psr_to_id shows it (bits 5,4 = 1).
  // m_hs: 0 = free to accept, 1 = just acked, 2 = waiting for drop.
  logic [7:0] m_psr = 8'h34;
  int         m_hs  = 0;
  int         m_age = 0;
  logic       m_ack = 1'b0;
  logic       m_err = 1'b0;
  logic       prev_ack = 1'b0;

  always begin
    @(posedge fclk);
    begin
      logic [7:0] nx;
      logic       take;
      if (resb) begin
        m_psr = 8'h34;
        m_hs  = 0;
        m_age = 0;
        m_ack = 1'b0;
        m_err = 1'b0;
      end else begin
        take = (m_hs == 0) && req && !plp;
        nx = m_psr;
        if (take) begin
          nx[7] = n_r; nx[6] = v_r; nx[1] = z_r; nx[0] = c_r;
        end
        if (fov) begin
          if (fop == 3'd0) nx[0] = 1'b0;
          if (fop == 3'd1) nx[0] = 1'b1;
          if (fop == 3'd2) nx[2] = 1'b0;
          if (fop == 3'd3) nx[2] = 1'b1;
          if (fop == 3'd4) nx[3] = 1'b0;
          if (fop == 3'd5) nx[3] = 1'b1;
          if (fop == 3'd6) nx[6] = 1'b0;
        end
        if (irq) begin
          nx[2] = 1'b1; nx[3] = 1'b0;
        end
        if (plp) nx = db | 8'h30;
        m_psr = nx;
        m_ack = take;
        if (take) begin
          m_hs = 1;
        end else if (m_hs == 1) begin
          m_hs = req ? 2 : 0;
        end else if (m_hs == 2) begin
          if (!req) begin
            m_hs = 0; m_age = 0;
          end else if (m_age + 1 >= DROP) begin
            m_err = 1'b1; m_age = 0; m_hs = 0;
          end else begin
            m_age = m_age + 1;
          end
        end
      end
    end
    #1;
    chk("psr_to_id", to_id, m_psr);
    chk("psr_push_out", push_out, {m_psr[7:5], pb, m_psr[3:0]});
    chk("c_carry", {7'd0, cc}, {7'd0, m_psr[0]});
    chk("d_decimal", {7'd0, dd}, {7'd0, m_psr[3]});
    chk("ack", {7'd0, ack}, {7'd0, m_ack});
    chk("update_pending", {7'd0, pend}, {7'd0, m_hs != 0});
    chk("protocol_error", {7'd0, perr}, {7'd0, m_err});
    chk("ack_not_twice", {7'd0, prev_ack & ack}, 8'd0);
    prev_ack = ack;
  end

  task automatic tick();
    @(posedge fclk);
    #2;
  endtask

  task automatic alu(input logic n, input logic v, input logic z,
                     input logic c);
    n_r = n; v_r = v; z_r = z; c_r = c;
  endtask

  initial begin
    resb = 1'b1; req = 1'b1; alu(0, 0, 0, 0);
    fov = 1'b0; fop = 3'd7; plp = 1'b0; db = 8'h00;
    irq = 1'b0; pb = 1'b0;
    tick();
    resb = 1'b0; req = 1'b0;
    chk("rst_to_id", to_id, 8'h34);
    chk("rst_push", push_out, 8'h24);
    chk("rst_ack", {7'd0, ack}, 8'd0);
    chk("rst_pend", {7'd0, pend}, 8'd0);

    // basic handshake
    req = 1'b1; alu(1, 0, 0, 1);
    tick();
    chk("hs_ack", {7'd0, ack}, 8'd1);
    chk("hs_to_id", to_id, 8'hB5);
    req = 1'b0;
    tick();
    chk("hs_ack_drop", {7'd0, ack}, 8'd0);
    chk("hs_idle", {7'd0, pend}, 8'd0);

    // SEC beats ALU carry
    fov = 1'b1; fop = 3'd1; req = 1'b1; alu(0, 0, 1, 0);
    tick();
    chk("sec_alu", to_id, 8'h37);
    fov = 1'b0; req = 1'b0;
    tick();
    // CLV beats ALU overflow
    fov = 1'b1; fop = 3'd6; req = 1'b1; alu(0, 1, 0, 0);
    tick();
    chk("clv_alu", to_id, 8'h34);
    fov = 1'b0; req = 1'b0;
    tick();

    // PLP defers the request by one cycle
    plp = 1'b1; db = 8'hCF; req = 1'b1; alu(0, 0, 0, 0);
    tick();
    chk("plp_to_id", to_id, 8'hFF);
    chk("plp_no_ack", {7'd0, ack}, 8'd0);
    plp = 1'b0;
    tick();
    chk("plp_late_ack", {7'd0, ack}, 8'd1);
    chk("plp_alu", to_id, 8'h3C);
    req = 1'b0;
    tick();

    // interrupt entry from 3C
    pb = 1'b0; irq = 1'b1;
    #1;
    chk("irq_push", push_out, 8'h2C);
    tick();
    chk("irq_to_id", to_id, 8'h34);
    irq = 1'b0;

    // drop timeout
    req = 1'b1;
    tick();
    chk("tmo_ack1", {7'd0, ack}, 8'd1);
    repeat (4) tick();
    chk("tmo_no_err", {7'd0, perr}, 8'd0);
    tick();
    chk("tmo_err", {7'd0, perr}, 8'd1);
    tick();
    chk("tmo_ack2", {7'd0, ack}, 8'd1);
    req = 1'b0;
    repeat (2) tick();

    // reset while in ACK
    req = 1'b1;
    tick();
    chk("mid_ack", {7'd0, ack}, 8'd1);
    resb = 1'b1;
    tick();
    chk("mid_rst_ack", {7'd0, ack}, 8'd0);
    chk("mid_rst_pend", {7'd0, pend}, 8'd0);
    chk("mid_rst_psr", to_id, 8'h34);
    chk("mid_rst_err", {7'd0, perr}, 8'd0);
    resb = 1'b0; req = 1'b0;
    tick();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      resb = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req = ~req;
      alu($urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1));
      fov = ($urandom_range(0, 2) == 0);
      fop = 3'($urandom_range(0, 7));
      plp = ($urandom_range(0, 7) == 0);
      db  = 8'($urandom);
      irq = ($urandom_range(0, 9) == 0);
      pb  = $urandom_range(0, 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
